// File: rtl/rvtest_monitor_if.sv
// Signal bundle between the core under test and the end-of-test monitor.
// The core side drives the observed state; the monitor side returns the verdict.
interface rvtest_monitor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_pc;
  logic             if_valid;
  logic [31:0]      gp;
  logic             st_en;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [30:0]      fail_num;
  logic [CNT_W-1:0] cycles;

  modport master (
    output if_pc, if_valid, gp, st_en, st_addr, st_data,
    input  done, pass, timeout, fail_num, cycles
  );

  modport slave (
    input  if_pc, if_valid, gp, st_en, st_addr, st_data,
    output done, pass, timeout, fail_num, cycles
  );
endinterface

// File: rtl/rvtest_monitor.sv
// End-of-test monitor for riscv-tests: watches the terminal-loop fetch, the tohost
// mailbox and a cycle budget, then latches a sticky pass/fail/timeout verdict.
module rvtest_monitor #(
  parameter logic [31:0] END_PC      = 32'h0000_0044,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          MAX_CYCLES  = 6000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  rvtest_monitor_if.slave  mon
);

  generate
    if (MAX_CYCLES <= 0 || longint'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_param
      $error("rvtest_monitor: MAX_CYCLES must be in 1 .. 2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [30:0]      r_fail_num;
  logic [30:0]      w_fail_val;
  logic             w_tohost_hit;
  logic             w_pc_hit;

  // A wrong-path fetch of END_PC is flushed with if_valid low and must not end the test.
  assign w_tohost_hit = mon.st_en && (mon.st_addr == TOHOST_ADDR) && mon.st_data[0];
  assign w_pc_hit     = mon.if_valid && (mon.if_pc == END_PC);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_fail_num <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_RUN && w_next == S_FAIL) begin
        r_fail_num <= w_fail_val;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_fail_val = '0;
    if (r_state == S_RUN) begin
      // Tohost outranks the terminal-loop fetch, which outranks the cycle budget.
      if (w_tohost_hit) begin
        w_next     = (mon.st_data == 32'd1) ? S_PASS : S_FAIL;
        w_fail_val = mon.st_data[31:1];
      end else if (w_pc_hit) begin
        w_next     = (mon.gp == 32'd1) ? S_PASS : S_FAIL;
        w_fail_val = mon.gp[31:1];
      end else if (r_cnt == CNT_LAST) begin
        w_next = S_TIMEOUT;
      end
    end
  end

  always_comb begin
    mon.done     = (r_state != S_RUN);
    mon.pass     = (r_state == S_PASS);
    mon.timeout  = (r_state == S_TIMEOUT);
    mon.fail_num = r_fail_num;
    mon.cycles   = r_cnt;
  end

endmodule
